tpsram_fifo_wconv: RTL and testbench

Parametrised successor to the fixed 512x64-in / 4096x8-out two-port RAM wrapper. It is a synchronous FIFO with wide writes and narrow reads. Each wide word is written in one beat and drained as RATIO narrow lanes, lowest lane first. Pointer, occupancy and error tracking are added, so producers (DMA/packet buffers) and byte-serial consumers no longer manage addresses themselves.

---
 rtl/tpsram_fifo_wconv.sv | 106 ++++++++++
 tb/tb_tpsram_fifo_wconv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tpsram_fifo_wconv.sv
// Width-converting synchronous FIFO: wide words written in one beat, drained as
// RATIO narrow lanes (lowest first) with occupancy, full/empty and sticky error flags.
module tpsram_fifo_wconv #(
   parameter int W_WIDTH = 64,
   parameter int RATIO   = 8,
   parameter int W_DEPTH = 512,
   localparam int R_WIDTH = W_WIDTH / RATIO,
   localparam int AW      = $clog2(W_DEPTH),
   localparam int LW      = $clog2(RATIO),
   localparam int CW      = $clog2(W_DEPTH * RATIO + 1),
   localparam int SW      = $clog2(W_DEPTH + 1)
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [W_WIDTH-1:0] W_DATA,
   input  logic               W_EN,
   output logic               W_FULL,
   input  logic               R_EN,
   output logic [R_WIDTH-1:0] R_DATA,
   output logic               R_VALID,
   output logic               R_EMPTY,
   output logic [CW-1:0]      R_COUNT,
   output logic               OVERFLOW,
   output logic               UNDERFLOW,
   input  logic               CLR_ERR
);

   logic [W_WIDTH-1:0] mem [W_DEPTH];
   logic [W_WIDTH-1:0] ram_q_reg;
   logic [R_WIDTH-1:0] lanes [RATIO];

   logic [AW-1:0]      wptr_reg, rptr_reg, rptr_next;
   logic [LW-1:0]      lane_reg;
   logic [CW-1:0]      count_reg, count_next;
   logic [SW-1:0]      slots_reg, slots_next;
   logic               full_reg, empty_reg, valid_reg, ovf_reg, unf_reg;
   logic [R_WIDTH-1:0] rdata_reg;
   logic               wr_ok, rd_ok, last_lane;

   assign wr_ok     = W_EN && !full_reg && !RESET;
   assign rd_ok     = R_EN && !empty_reg;
   assign last_lane = rd_ok && (lane_reg == LW'(RATIO - 1));
   assign rptr_next = last_lane ? rptr_reg + 1'b1 : rptr_reg;

   // The RAM port always presents the slot being drained, so the lane mux plus
   // one output register gives single-cycle read latency. A write landing in
   // that slot on the same edge is forwarded, since the array read is old-data.
   always_ff @(posedge CLK) begin
      if (wr_ok)
         mem[wptr_reg] <= W_DATA;
      if (wr_ok && (wptr_reg == rptr_next))
         ram_q_reg <= W_DATA;
      else
         ram_q_reg <= mem[rptr_next];
   end

   for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lanes[gi] = ram_q_reg[gi*R_WIDTH +: R_WIDTH];
   end

   always_comb begin
      count_next = count_reg + (wr_ok ? CW'(RATIO) : CW'(0)) - (rd_ok ? CW'(1) : CW'(0));
      slots_next = slots_reg + (wr_ok ? SW'(1) : SW'(0)) - (last_lane ? SW'(1) : SW'(0));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         lane_reg  <= '0;
         count_reg <= '0;
         slots_reg <= '0;
         full_reg  <= 1'b0;
         empty_reg <= 1'b1;
         valid_reg <= 1'b0;
         rdata_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         if (wr_ok)
            wptr_reg <= wptr_reg + 1'b1;
         if (rd_ok) begin
            lane_reg  <= lane_reg + 1'b1;
            rdata_reg <= lanes[lane_reg];
         end
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
         slots_reg <= slots_next;
         // A partly drained slot still counts as occupied.
         full_reg  <= (slots_next == SW'(W_DEPTH));
         empty_reg <= (count_next == '0);
         valid_reg <= rd_ok;
         ovf_reg   <= (W_EN && full_reg) || (ovf_reg && !CLR_ERR);
         unf_reg   <= (R_EN && empty_reg) || (unf_reg && !CLR_ERR);
      end
   end

   assign W_FULL    = full_reg;
   assign R_EMPTY   = empty_reg;
   assign R_COUNT   = count_reg;
   assign R_VALID   = valid_reg;
   assign R_DATA    = rdata_reg;
   assign OVERFLOW  = ovf_reg;
   assign UNDERFLOW = unf_reg;

endmodule

// File: tb/tb_tpsram_fifo_wconv.sv
// Directed and random-phase bench for tpsram_fifo_wconv with a lane-queue reference model.
module tb_tpsram_fifo_wconv;
   localparam int W_W   = 64;
   localparam int RATIO = 8;
   localparam int DEPTH = 512;
   localparam int R_W   = W_W / RATIO;
   localparam int CW    = $clog2(DEPTH * RATIO + 1);

   logic           clk = 1'b0;
   logic           reset, w_en, r_en, clr_err;
   logic [W_W-1:0] w_data;
   logic           w_full, r_valid, r_empty, overflow, underflow;
   logic [R_W-1:0] r_data;
   logic [CW-1:0]  r_count;

   tpsram_fifo_wconv #(.W_WIDTH(W_W), .RATIO(RATIO), .W_DEPTH(DEPTH)) dut (
      .CLK(clk), .RESET(reset), .W_DATA(w_data), .W_EN(w_en), .W_FULL(w_full),
      .R_EN(r_en), .R_DATA(r_data), .R_VALID(r_valid), .R_EMPTY(r_empty),
      .R_COUNT(r_count), .OVERFLOW(overflow), .UNDERFLOW(underflow), .CLR_ERR(clr_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of narrow lanes in delivery order.
   logic [R_W-1:0] mq [$];
   logic [R_W-1:0] m_data;
   logic           m_valid, m_ovf, m_unf;
   logic           model_on = 1'b0;
   int             m_writes = 0;

   function automatic bit m_full();
      return ((mq.size() + RATIO - 1) / RATIO) == DEPTH;
   endfunction

   always @(posedge clk) begin
      automatic bit mf = m_full();
      automatic bit me = (mq.size() == 0);
      if (reset) begin
         mq.delete();
         m_data   <= '0;
         m_valid  <= 1'b0;
         m_ovf    <= 1'b0;
         m_unf    <= 1'b0;
         model_on <= 1'b1;
      end else if (model_on) begin
         m_valid <= r_en && !me;
         if (r_en && !me)
            m_data <= mq.pop_front();
         if (w_en && !mf) begin
            for (int k = 0; k < RATIO; k++)
               mq.push_back(w_data[k*R_W +: R_W]);
            m_writes <= m_writes + 1;
         end
         m_ovf <= (w_en && mf) || (m_ovf && !clr_err);
         m_unf <= (r_en && me) || (m_unf && !clr_err);
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("r_data",    64'(r_data),    64'(m_data));
         chk("r_valid",   64'(r_valid),   64'(m_valid));
         chk("r_count",   64'(r_count),   64'(mq.size()));
         chk("r_empty",   64'(r_empty),   64'(mq.size() == 0));
         chk("w_full",    64'(w_full),    64'(m_full()));
         chk("overflow",  64'(overflow),  64'(m_ovf));
         chk("underflow", 64'(underflow), 64'(m_unf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W_W-1:0] word(input int i);
      return 64'(i) * 64'h0123456789ABCDEF;
   endfunction

   initial begin
      int w0;
      int pw, pr;
      reset = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; w_data = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_count", 64'(r_count), 64'd0);
      chk("rst_empty", 64'(r_empty), 64'd1);
      chk("rst_full",  64'(w_full),  64'd0);
      chk("rst_data",  64'(r_data),  64'd0);
      chk("rst_valid", 64'(r_valid), 64'd0);

      // Basic conversion
      w_en = 1'b1; w_data = 64'h0807060504030201;
      tick();
      w_en = 1'b0;
      chk("basic_count", 64'(r_count), 64'd8);
      r_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("basic_valid", 64'(r_valid), 64'd1);
         chk("basic_data",  64'(r_data),  64'(i + 1));
      end
      r_en = 1'b0;
      chk("basic_drained", 64'(r_count), 64'd0);
      chk("basic_empty",   64'(r_empty), 64'd1);
      tick();
      chk("basic_strobe", 64'(r_valid), 64'd0);

      // Underflow and clear
      r_en = 1'b1; tick(); r_en = 1'b0;
      chk("unf_set",   64'(underflow), 64'd1);
      chk("unf_valid", 64'(r_valid),   64'd0);
      chk("unf_hold",  64'(r_data),    64'h08);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      chk("unf_clear", 64'(underflow), 64'd0);
      clr_err = 1'b1; r_en = 1'b1; tick(); clr_err = 1'b0; r_en = 1'b0;
      chk("unf_wins", 64'(underflow), 64'd1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;

      // Fill, overflow, drain in order
      w_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         w_data = word(i);
         tick();
      end
      chk("fill_full",  64'(w_full),  64'd1);
      chk("fill_count", 64'(r_count), 64'(DEPTH * RATIO));
      w_data = word(9999);
      tick();
      w_en = 1'b0;
      chk("ovf_set",   64'(overflow), 64'd1);
      chk("ovf_count", 64'(r_count),  64'(DEPTH * RATIO));
      r_en = 1'b1;
      for (int j = 0; j < DEPTH * RATIO; j++) begin
         tick();
         if (j == 0) chk("drain_first", 64'(r_data), 64'h00);
      end
      r_en = 1'b0;
      chk("drain_last",  64'(r_data),  64'h45);
      chk("drain_empty", 64'(r_empty), 64'd1);
      clr_err = 1'b1; tick(); clr_err = 1'b0;

      // Full with simultaneous read
      w_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         w_data = word(i + 1000);
         tick();
      end
      r_en = 1'b1; w_data = word(7777);
      tick();
      w_en = 1'b0; r_en = 1'b0;
      chk("fullrd_valid", 64'(r_valid),  64'd1);
      chk("fullrd_data",  64'(r_data),   64'h98);
      chk("fullrd_ovf",   64'(overflow), 64'd1);
      chk("fullrd_count", 64'(r_count),  64'(DEPTH * RATIO - 1));
      tick();
      chk("fullrd_still_full", 64'(w_full), 64'd1);
      r_en = 1'b1;
      for (int j = 0; j < DEPTH * RATIO - 1; j++) tick();
      r_en = 1'b0;
      clr_err = 1'b1; tick(); clr_err = 1'b0;

      // Mid-operation reset
      w_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_data = word(i + 2000);
         tick();
      end
      w_en = 1'b0; r_en = 1'b1;
      for (int j = 0; j < 5; j++) tick();
      reset = 1'b1; w_en = 1'b1; w_data = word(3000);
      tick();
      reset = 1'b0; w_en = 1'b0; r_en = 1'b0;
      chk("mrst_count", 64'(r_count),   64'd0);
      chk("mrst_empty", 64'(r_empty),   64'd1);
      chk("mrst_data",  64'(r_data),    64'd0);
      chk("mrst_ovf",   64'(overflow),  64'd0);
      chk("mrst_unf",   64'(underflow), 64'd0);
      w_en = 1'b1; w_data = 64'hCAFEBABEDEADBEEF;
      tick();
      w_en = 1'b0; r_en = 1'b1;
      tick();
      r_en = 1'b0;
      chk("mrst_new_valid", 64'(r_valid), 64'd1);
      chk("mrst_new_data",  64'(r_data),  64'hEF);

      // Random traffic in phases: fill-biased, two drains, balanced
      w0 = m_writes;
      for (int cyc = 0; cyc < 28000; cyc++) begin
         case ((cyc / 1000) % 4)
            0:       begin pw = 40; pr = 30;  end
            1, 2:    begin pw = 0;  pr = 100; end
            default: begin pw = 12; pr = 100; end
         endcase
         w_en    = ($urandom_range(99) < pw);
         r_en    = ($urandom_range(99) < pr);
         clr_err = ($urandom_range(199) == 0);
         w_data  = {$urandom, $urandom};
         tick();
      end
      w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
      tick();
      chk("rand_wraps", 64'(m_writes - w0 >= 4 * DEPTH), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
